// File: rtl/gpu_pipe_pkg.sv
// Shared definitions for the GPU pixel pipeline schedulers: FSM encoding and
// default layer-count constants.
package gpu_pipe_pkg;

  localparam int NUM_LAYERS_DEFAULT = 32;
  localparam int LAYER_W_DEFAULT    = $clog2(NUM_LAYERS_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/layer_scan_sched_if.sv
// Request channel from the layer scan scheduler to the layer fetch/blend stage.
// The master drives valid and payload; the slave answers with ready.
interface layer_scan_sched_if
  import gpu_pipe_pkg::*;
#(
  parameter int LAYER_W = LAYER_W_DEFAULT,
  parameter int X_W     = 10,
  parameter int Y_W     = 9
);

  logic               req_valid;
  logic               req_ready;
  logic [LAYER_W-1:0] req_layer;
  logic [X_W-1:0]     req_x;
  logic [Y_W-1:0]     req_y;
  logic               req_last;

  modport master (
    output req_valid, req_layer, req_x, req_y, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_layer, req_x, req_y, req_last,
    output req_ready
  );

endinterface

// File: rtl/next_layer_find.sv
// Combinational layer search over an enable mask: the next enabled layer above
// the current one, the lowest enabled layer, and whether any layer is enabled.
module next_layer_find
  import gpu_pipe_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEFAULT,
  parameter int LAYER_W    = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0] mask,
  input  logic [LAYER_W-1:0]    cur_layer,
  output logic [LAYER_W-1:0]    next_layer,
  output logic                  next_found,
  output logic [LAYER_W-1:0]    low_layer,
  output logic                  mask_any
);

  // Enabled layers strictly above the current one
  logic [NUM_LAYERS-1:0] above;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_above
      assign above[gi] = mask[gi] && (LAYER_W'(gi) > cur_layer);
    end
  endgenerate

  // Priority encode from the top down so the lowest qualifying bit wins
  always_comb begin
    next_layer = '0;
    low_layer  = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (above[i]) next_layer = LAYER_W'(i);
      if (mask[i])  low_layer  = LAYER_W'(i);
    end
  end

  assign next_found = |above;
  assign mask_any   = |mask;

endmodule

// File: rtl/layer_scan_sched.sv
// Per-pixel layer walk scheduler: for every pixel of the frame, issues one
// request per enabled layer in ascending order, then advances the raster.
module layer_scan_sched
  import gpu_pipe_pkg::*;
#(
  parameter int  NUM_LAYERS = NUM_LAYERS_DEFAULT,
  parameter int  H_RES      = 640,
  parameter int  V_RES      = 480,
  localparam int LAYER_W    = $clog2(NUM_LAYERS),
  localparam int X_W        = $clog2(H_RES),
  localparam int Y_W        = $clog2(V_RES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_en,
  layer_scan_sched_if.master    req,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  state_t                state_reg, state_next;
  logic [NUM_LAYERS-1:0] mask_reg, mask_next;
  logic [LAYER_W-1:0]    layer_reg, layer_next;
  logic [X_W-1:0]        x_reg, x_next;
  logic [Y_W-1:0]        y_reg, y_next;

  logic [NUM_LAYERS-1:0] search_mask;
  logic [LAYER_W-1:0]    next_layer, low_layer;
  logic                  next_found, mask_any;
  logic                  issuing, handshake;

  // In IDLE the search looks at the incoming enables so the first layer is
  // ready the cycle start is accepted; afterwards it walks the latched mask.
  assign search_mask = (state_reg == ST_IDLE) ? layer_en : mask_reg;

  next_layer_find #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W)
  ) u_find (
    .mask       (search_mask),
    .cur_layer  (layer_reg),
    .next_layer (next_layer),
    .next_found (next_found),
    .low_layer  (low_layer),
    .mask_any   (mask_any)
  );

  assign issuing   = (state_reg == ST_ISSUE);
  assign handshake = issuing && req.req_ready;

  // State, latched mask and raster position registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mask_reg  <= '0;
      layer_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      layer_reg <= layer_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
    end
  end

  // Next-state: frame start, layer/raster advance on handshake, abort
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    layer_next = layer_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          mask_next  = layer_en;
          layer_next = low_layer;
          x_next     = '0;
          y_next     = '0;
          state_next = mask_any ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        // Abort overrides the hold rule; a coincident handshake is not replayed
        if (abort) begin
          state_next = ST_DONE;
        end else if (handshake) begin
          if (next_found) begin
            layer_next = next_layer;
          end else begin
            layer_next = low_layer;
            if (x_reg == X_LAST) begin
              if (y_reg == Y_LAST) begin
                state_next = ST_DONE;
              end else begin
                x_next = '0;
                y_next = y_reg + Y_W'(1);
              end
            end else begin
              x_next = x_reg + X_W'(1);
            end
          end
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign req.req_valid = issuing;
  assign req.req_layer = layer_reg;
  assign req.req_x     = x_reg;
  assign req.req_y     = y_reg;
  assign req.req_last  = issuing && !next_found;
  assign busy          = (state_reg != ST_IDLE);
  assign frame_done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_layer_scan_sched.sv
// Directed testbench for layer_scan_sched on a 4x2 frame with 32 layers.
module tb_layer_scan_sched;

  localparam int NL = 32;
  localparam int HR = 4;
  localparam int VR = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] layer_en;
  logic        busy;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  layer_scan_sched_if #(.LAYER_W(5), .X_W(2), .Y_W(1)) req_if ();

  layer_scan_sched #(
    .NUM_LAYERS (NL),
    .H_RES      (HR),
    .V_RES      (VR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .layer_en   (layer_en),
    .req        (req_if),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    int          ready_mode;   // 0: always ready, 1: stall pattern
    bit          meddle;       // pulse start + change layer_en mid-frame
    int          exp_count;
    int          exp_first;    // layer of the first request
    int          exp_final;    // layer of the final request
  } vec_t;

  typedef struct {
    logic [4:0] layer;
    logic [1:0] x;
    logic [0:0] y;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  bit   ready_pat [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference walk: every pixel in raster order, every enabled layer ascending
  task automatic build_exp(input logic [31:0] m);
    logic [31:0] mm;
    exp_t e;
    mm = m;
    exp_q.delete();
    for (int y = 0; y < VR; y++)
      for (int x = 0; x < HR; x++)
        for (int l = 0; l < NL; l++)
          if (mm[l]) begin
            e.layer = 5'(l);
            e.x     = 2'(x);
            e.y     = 1'(y);
            e.last  = ((mm >> (l + 1)) == 32'd0);
            exp_q.push_back(e);
          end
  endtask

  function automatic logic [8:0] payload();
    return {req_if.req_layer, req_if.req_x, req_if.req_y, req_if.req_last};
  endfunction

  task automatic run_frame(input vec_t v, input int tno);
    int         idx = 0;
    int         cyc = 0;
    int         last_hs = -1;
    int         done_cyc = -1;
    int         bubbles = 0;
    int         first_l = -1;
    int         final_l = -1;
    bit         pv = 0;
    bit         pr = 0;
    bit         rdy;
    logic [8:0] held = '0;
    logic [8:0] expv;
    build_exp(v.mask);
    @(negedge clk);
    layer_en = v.mask;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    while (cyc < 3000) begin
      rdy = (v.ready_mode == 0) ? 1'b1 : ready_pat[cyc % 10];
      req_if.req_ready = rdy;
      if (v.meddle && cyc == 3) begin
        start    = 1'b1;
        layer_en = 32'hFFFF_FFFF;
      end
      if (v.meddle && cyc == 4) start = 1'b0;
      if (frame_done) begin
        done_cyc = cyc;
        break;
      end
      if (pv && !pr) begin
        chk($sformatf("t%0d stall_valid c%0d", tno, cyc), req_if.req_valid, 1);
        chk($sformatf("t%0d stall_hold c%0d", tno, cyc), payload(), held);
      end
      if (req_if.req_valid) begin
        if (rdy) begin
          if (idx < exp_q.size()) begin
            expv = {exp_q[idx].layer, exp_q[idx].x, exp_q[idx].y, exp_q[idx].last};
            chk($sformatf("t%0d req%0d", tno, idx), payload(), expv);
          end else begin
            chk($sformatf("t%0d extra_req%0d", tno, idx), payload(), 9'h1FF);
          end
          if (first_l < 0) first_l = int'(req_if.req_layer);
          final_l = int'(req_if.req_layer);
          idx++;
          last_hs = cyc;
        end
      end else begin
        bubbles++;
      end
      pv   = req_if.req_valid;
      pr   = rdy;
      held = payload();
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("t%0d req_count", tno), idx, v.exp_count);
    chk($sformatf("t%0d done_timing", tno), done_cyc, last_hs + 1);
    chk($sformatf("t%0d busy_at_done", tno), busy, 1);
    if (v.exp_count > 0) begin
      chk($sformatf("t%0d first_layer", tno), first_l, v.exp_first);
      chk($sformatf("t%0d final_layer", tno), final_l, v.exp_final);
    end
    if (v.ready_mode == 0) chk($sformatf("t%0d bubbles", tno), bubbles, 0);
    @(negedge clk);
    chk($sformatf("t%0d idle_after", tno), {busy, frame_done, req_if.req_valid}, 3'b000);
    $display("t%0d mask=%08h requests=%0d done_cycle=%0d", tno, v.mask, idx, done_cyc);
  endtask

  vec_t vecs [5];
  vec_t rerun;

  initial begin
    vecs[0] = '{32'h0000_0001, 0, 1'b0,  8, 0,  0};
    vecs[1] = '{32'h8000_0011, 0, 1'b0, 24, 0, 31};
    vecs[2] = '{32'h0000_0006, 1, 1'b0, 16, 1,  2};
    vecs[3] = '{32'h0000_0000, 0, 1'b0,  0, 0,  0};
    vecs[4] = '{32'h0000_0005, 1, 1'b1, 16, 0,  2};
    rerun   = '{32'h0000_0006, 0, 1'b0, 16, 1,  2};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    layer_en = '0;
    req_if.req_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {req_if.req_valid, payload(), busy, frame_done}, 12'h000);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i + 1);

    // Abort in IDLE does nothing
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, frame_done, req_if.req_valid}, 3'b000);
    $display("abort in idle ignored");

    // Abort on the 5th request while it is stalled
    layer_en = 32'h6;
    start    = 1'b1;
    req_if.req_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    req_if.req_ready = 1'b0;
    chk("abort_req5_payload", {req_if.req_valid, payload()}, {1'b1, 5'd1, 2'd2, 1'b0, 1'b0});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid_drop", req_if.req_valid, 0);
    chk("abort_done_pulse", {frame_done, busy}, 2'b11);
    @(negedge clk);
    chk("abort_idle_after", {busy, frame_done}, 2'b00);
    $display("abort at request 5 handled");

    // Asynchronous reset mid-frame
    layer_en = 32'h6;
    start    = 1'b1;
    req_if.req_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_outputs",
        {req_if.req_valid, payload(), busy, frame_done}, 12'h000);
    @(negedge clk);
    chk("reset_no_done", frame_done, 0);
    reset = 1'b0;
    $display("mid-frame reset cleared outputs");
    run_frame(rerun, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
